// File: rtl/a_to_sync.sv
// a_to_sync: 2-phase bundled-data async channel -> clocked valid/ready stream.
// r_i is synchronized.
// a_i is a registered toggle.
// Accepted tokens are written to a small FIFO.
// Optional feature macro: A_TO_SYNC_STALL_CNT_EN (adds stall_cnt_o).
module a_to_sync #(
    parameter logic        Rpol        = 1'b0,
    parameter int unsigned N           = 32'd1,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     r_i,
    output logic                     a_i,
    input  logic [N-1:0]             d_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [N-1:0]             d_o,
    output logic [$clog2(DEPTH):0]   count_o
`ifdef A_TO_SYNC_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ack_q, ack_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [N-1:0]           mem [DEPTH];

    logic r_s;
    logic pending;
    logic accept;
    logic rd_fire;

    // Shift r_i into the synchronizer chain; only r_i crosses, d_i is bundled.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], r_i};
    end

    assign r_s = sync_q[SYNC_STAGES-1];

    // Accept/read decisions and next-state for ack, pointers and occupancy.
    always_comb begin
        pending  = r_s ^ ack_q;
        accept   = pending && (count_q != FULL);
        rd_fire  = (count_q != '0) && ready_i;
        ack_d    = ack_q ^ accept;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({accept, rd_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers; reset returns the handshake to the idle level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= {SYNC_STAGES{Rpol}};
            ack_q    <= Rpol;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            sync_q   <= sync_d;
            ack_q    <= ack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; d_i is stable here because accept follows the sync delay.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= d_i;
        end
    end

`ifdef A_TO_SYNC_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Count cycles where a token waits on a full FIFO, saturating.
    always_comb begin
        stall_d = stall_q;
        if (pending && (count_q == FULL) && (stall_q != '1)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

    assign a_i     = ack_q;
    assign valid_o = (count_q != '0);
    assign count_o = count_q;
    // Head is masked to zero when empty so d_o is defined without resetting storage.
    assign d_o     = valid_o ? mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_a_to_sync.sv
// Scoreboard bench for a_to_sync: Rpol=0 main instance plus an Rpol=1 instance.
module tb_a_to_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       r_i, a_i, valid_o, ready_i;
    logic [7:0] d_i, d_o;
    logic [2:0] count_o;
    logic       r1, a1, valid1, ready1;
    logic [7:0] d1, d1o;
    logic [2:0] cnt1;
`ifdef A_TO_SYNC_STALL_CNT_EN
    logic [15:0] stall_cnt_o, stall1;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp1_q[$];

    always #5 clk = ~clk;

    a_to_sync #(.Rpol(1'b0), .N(8), .DEPTH(4), .SYNC_STAGES(2)) u_dut0 (
        .clk(clk), .rst(rst), .r_i(r_i), .a_i(a_i), .d_i(d_i),
        .valid_o(valid_o), .ready_i(ready_i), .d_o(d_o), .count_o(count_o)
`ifdef A_TO_SYNC_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    a_to_sync #(.Rpol(1'b1), .N(8), .DEPTH(4), .SYNC_STAGES(2)) u_dut1 (
        .clk(clk), .rst(rst), .r_i(r1), .a_i(a1), .d_i(d1),
        .valid_o(valid1), .ready_i(ready1), .d_o(d1o), .count_o(cnt1)
`ifdef A_TO_SYNC_STALL_CNT_EN
        , .stall_cnt_o(stall1)
`endif
    );

    task automatic send(input logic [7:0] v);
        @(negedge clk);
        d_i = v;
        r_i = ~r_i;
        exp_q.push_back(v);
    endtask

    task automatic wait_ack(input int max, output int edges);
        edges = 0;
        while (a_i !== r_i && edges < max) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic drain(input int n);
        int got = 0;
        int cyc = 0;
        @(negedge clk);
        ready_i = 1'b1;
        while (got < n && cyc < 50) begin
            if (valid_o === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL drain_unexpected: got %0h required none", d_o);
                end else begin
                    if (d_o !== exp_q[0]) begin
                        n_bad++;
                        $display("FAIL drain_data: got %0h required %0h", d_o, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        ready_i = 1'b0;
        n_cmp++;
        if (got != n) begin
            n_bad++;
            $display("FAIL drain_count: got %0d required %0d", got, n);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({a_i, valid_o, count_o, d_o} !== 13'h0) begin
            n_bad++;
            $display("FAIL reset_held: got a=%b v=%b c=%0d d=%0h required 0", a_i, valid_o, count_o, d_o);
        end
        n_cmp++;
        if (a1 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_rpol1_ack: got %b required 1", a1);
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({a_i, valid_o, count_o, d_o} !== 13'h0) begin
            n_bad++;
            $display("FAIL reset_release_idle: got a=%b v=%b c=%0d d=%0h required 0", a_i, valid_o, count_o, d_o);
        end
    endtask

    task automatic test_single;
        int e;
        send(8'hA5);
        wait_ack(10, e);
        n_cmp++;
        if (e != 3 || a_i !== 1'b1) begin
            n_bad++;
            $display("FAIL single_latency: got %0d edges a=%b required 3 edges a=1", e, a_i);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (valid_o !== 1'b1 || count_o !== 3'd1 || d_o !== exp_q[0]) begin
            n_bad++;
            $display("FAIL single_out: got v=%b c=%0d d=%0h required v=1 c=1 d=%0h", valid_o, count_o, d_o, exp_q[0]);
        end
        drain(1);
    endtask

    task automatic test_fill;
        int e;
        for (int i = 1; i <= 4; i++) begin
            send(8'(i));
            wait_ack(10, e);
            n_cmp++;
            if (a_i !== r_i) begin
                n_bad++;
                $display("FAIL fill_ack: token %0d got a=%b required %b", i, a_i, r_i);
            end
        end
        n_cmp++;
        if (count_o !== 3'd4) begin
            n_bad++;
            $display("FAIL fill_count: got %0d required 4", count_o);
        end
        send(8'd5);
        repeat (12) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (a_i === r_i || count_o !== 3'd4) begin
            n_bad++;
            $display("FAIL full_hold: got a=%b c=%0d required a!=%b c=4", a_i, count_o, r_i);
        end
`ifdef A_TO_SYNC_STALL_CNT_EN
        n_cmp++;
        if (stall_cnt_o !== 16'd10) begin
            n_bad++;
            $display("FAIL stall_cnt: got %0d required 10", stall_cnt_o);
        end
`endif
        ready_i = 1'b1;
        n_cmp++;
        if (d_o !== exp_q[0]) begin
            n_bad++;
            $display("FAIL full_pop_data: got %0h required %0h", d_o, exp_q[0]);
        end
        void'(exp_q.pop_front());
        @(negedge clk);
        ready_i = 1'b0;
        n_cmp++;
        if (count_o !== 3'd3 || a_i === r_i) begin
            n_bad++;
            $display("FAIL full_same_cycle: got c=%0d a=%b required c=3 a held", count_o, a_i);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (count_o !== 3'd4 || a_i !== r_i) begin
            n_bad++;
            $display("FAIL full_late_accept: got c=%0d a=%b required c=4 a=%b", count_o, a_i, r_i);
        end
        drain(4);
    endtask

    task automatic test_stream;
        int got = 0;
        ready_i = 1'b1;
        fork
            begin
                int e;
                for (int i = 0; i < 16; i++) begin
                    send(8'(i));
                    wait_ack(20, e);
                    n_cmp++;
                    if (a_i !== r_i) begin
                        n_bad++;
                        $display("FAIL stream_ack: token %0d got a=%b required %b", i, a_i, r_i);
                    end
                end
            end
            begin
                int cyc = 0;
                while (got < 16 && cyc < 1000) begin
                    @(negedge clk);
                    cyc++;
                    if (valid_o === 1'b1) begin
                        n_cmp++;
                        if (exp_q.size() == 0) begin
                            n_bad++;
                            $display("FAIL stream_dup: got %0h required none", d_o);
                        end else begin
                            if (d_o !== exp_q[0]) begin
                                n_bad++;
                                $display("FAIL stream_data: got %0h required %0h", d_o, exp_q[0]);
                            end
                            void'(exp_q.pop_front());
                        end
                        got++;
                    end
                end
            end
        join
        @(negedge clk);
        ready_i = 1'b0;
        n_cmp++;
        if (got != 16 || exp_q.size() != 0 || valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_total: got %0d left %0d v=%b required 16 0 0", got, exp_q.size(), valid_o);
        end
    endtask

    task automatic test_reset_mid;
        int e;
        for (int i = 0; i < 3; i++) begin
            send(8'(8'h70 + i));
            wait_ack(10, e);
        end
        send(8'h77);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        r_i = 1'b0;
        r1  = 1'b1;
        #1;
        n_cmp++;
        if ({a_i, valid_o, count_o, d_o} !== 13'h0) begin
            n_bad++;
            $display("FAIL reset_async: got a=%b v=%b c=%0d d=%0h required 0", a_i, valid_o, count_o, d_o);
        end
`ifdef A_TO_SYNC_STALL_CNT_EN
        n_cmp++;
        if (stall_cnt_o !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_stall: got %0d required 0", stall_cnt_o);
        end
`endif
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (a_i !== 1'b0 || count_o !== 3'd0 || valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_no_phantom: got a=%b c=%0d v=%b required 0", a_i, count_o, valid_o);
        end
        send(8'h3C);
        wait_ack(10, e);
        drain(1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (valid_o !== 1'b0 || count_o !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_only_one: got v=%b c=%0d required 0 0", valid_o, count_o);
        end
    endtask

    task automatic test_rpol1;
        int e = 0;
        n_cmp++;
        if (a1 !== 1'b1) begin
            n_bad++;
            $display("FAIL rpol1_idle_ack: got %b required 1", a1);
        end
        @(negedge clk);
        d1 = 8'h5A;
        r1 = 1'b0;
        exp1_q.push_back(8'h5A);
        while (a1 !== r1 && e < 10) begin
            @(posedge clk);
            #1;
            e++;
        end
        n_cmp++;
        if (e != 3 || a1 !== 1'b0) begin
            n_bad++;
            $display("FAIL rpol1_latency: got %0d edges a=%b required 3 edges a=0", e, a1);
        end
        @(negedge clk);
        n_cmp++;
        if (valid1 !== 1'b1 || cnt1 !== 3'd1 || d1o !== exp1_q[0]) begin
            n_bad++;
            $display("FAIL rpol1_out: got v=%b c=%0d d=%0h required v=1 c=1 d=%0h", valid1, cnt1, d1o, exp1_q[0]);
        end
        void'(exp1_q.pop_front());
        ready1 = 1'b1;
        @(negedge clk);
        ready1 = 1'b0;
        n_cmp++;
        if (valid1 !== 1'b0) begin
            n_bad++;
            $display("FAIL rpol1_drained: got %b required 0", valid1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        r_i = 1'b0; d_i = '0; ready_i = 1'b0;
        r1  = 1'b1; d1  = '0; ready1  = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_reset_mid();
        test_rpol1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
